// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the system reset and, after a stagger, the video reset.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       pll_reset_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       video_reset_n,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [7:0] timeout_count,
  output logic [2:0] dbg_state
);

  localparam int M0      = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int M1      = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
  localparam int CNT_MAX = (M0 > M1) ? M0 : M1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_REL_SYS   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   loss_inc, timeout_inc;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d     = S_PLL_RST;
          timeout_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s) state_d = S_WAIT_LOCK;
        else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) state_d = S_REL_SYS;
      end
      S_REL_SYS: begin
        if (!locked_s) begin
          state_d  = S_PLL_RST;
          loss_inc = 1'b1;
        end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;  // RUN has no timed exit; hold so the counter never wraps
        if (!locked_s) begin
          state_d  = S_PLL_RST;
          loss_inc = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
    // A software request restarts the PLL pulse from any state, but a
    // simultaneous lock loss is still recorded.
    if (pll_reset_req) begin
      state_d     = S_PLL_RST;
      timeout_inc = 1'b0;
    end
    if (state_d != state_q || pll_reset_req) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_PLL_RST;
      cnt_q           <= '0;
      sync_q          <= '0;
      pll_rst         <= 1'b1;
      sys_reset_n     <= 1'b0;
      video_reset_n   <= 1'b0;
      ready           <= 1'b0;
      lock_loss_count <= '0;
      timeout_count   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q[0] <= pll_locked;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      // Outputs decode the next state so they change on the same edge as it.
      pll_rst       <= (state_d == S_PLL_RST);
      sys_reset_n   <= (state_d == S_REL_SYS) || (state_d == S_RUN);
      video_reset_n <= (state_d == S_RUN);
      ready         <= (state_d == S_RUN);
      if (loss_inc && lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
      if (timeout_inc && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_reset_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       video_reset_n;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [7:0] timeout_count;
  logic [2:0] dbg_state;

  int tests = 0;
  int fails = 0;
  logic [0:0] exp_q[$];

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8), .STAGGER_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .pll_reset_req(pll_reset_req), .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n), .video_reset_n(video_reset_n), .ready(ready),
    .lock_loss_count(lock_loss_count), .timeout_count(timeout_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = sys_reset_n, 1 = pll_rst, 2 = ready
  task automatic wait_sig(input int which, input int budget, input string tag);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n <= budget && !hit; n++) begin
      case (which)
        0:       hit = (sys_reset_n === 1'b1);
        1:       hit = (pll_rst === 1'b1);
        default: hit = (ready === 1'b1);
      endcase
      if (!hit) step();
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  // Raise lock while in WAIT_LOCK; E0 is the first edge that samples it.
  task automatic relock(input string tag);
    pll_locked = 1'b1;
    repeat (10) step();
    chk({tag, "_sys_e9"}, {31'd0, sys_reset_n}, 32'd0);
    step();
    chk({tag, "_sys_e10"}, {31'd0, sys_reset_n}, 32'd1);
    chk({tag, "_vid_e10"}, {31'd0, video_reset_n}, 32'd0);
    chk({tag, "_rdy_e10"}, {31'd0, ready}, 32'd0);
    repeat (2) step();
    chk({tag, "_vid_e12"}, {31'd0, video_reset_n}, 32'd0);
    step();
    chk({tag, "_vid_e13"}, {31'd0, video_reset_n}, 32'd1);
    chk({tag, "_rdy_e13"}, {31'd0, ready}, 32'd1);
    chk({tag, "_pllrst_e13"}, {31'd0, pll_rst}, 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    pll_locked    = 1'b0;
    pll_reset_req = 1'b0;
    repeat (3) step();
    chk("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("rst_sys", {31'd0, sys_reset_n}, 32'd0);
    chk("rst_vid", {31'd0, video_reset_n}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_loss", {24'd0, lock_loss_count}, 32'd0);
    chk("rst_tmo", {24'd0, timeout_count}, 32'd0);
    reset_n = 1'b1;

    // No lock: 4-cycle pulse, 20-cycle wait, repeated.
    repeat (3)  exp_q.push_back(1'b1);
    repeat (20) exp_q.push_back(1'b0);
    repeat (4)  exp_q.push_back(1'b1);
    repeat (20) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int k = 1; k <= 48; k++) begin
      step();
      chk($sformatf("tmo_pll_rst_k%0d", k), {31'd0, pll_rst}, {31'd0, exp_q.pop_front()});
      if (k == 23) chk("tmo_cnt_before", {24'd0, timeout_count}, 32'd0);
      if (k == 24) chk("tmo_cnt_1", {24'd0, timeout_count}, 32'd1);
      if (k == 48) chk("tmo_cnt_2", {24'd0, timeout_count}, 32'd2);
      if (k == 48) chk("tmo_sys_held", {31'd0, sys_reset_n}, 32'd0);
    end

    // Lock during WAIT_LOCK.
    repeat (5) step();
    chk("lock_in_wait", {29'd0, dbg_state}, 32'd1);
    relock("lock1");

    // Lock loss in RUN.
    pll_locked = 1'b0;
    repeat (2) step();
    chk("loss_d2_sys", {31'd0, sys_reset_n}, 32'd1);
    chk("loss_d2_ready", {31'd0, ready}, 32'd1);
    step();
    chk("loss_d3_sys", {31'd0, sys_reset_n}, 32'd0);
    chk("loss_d3_vid", {31'd0, video_reset_n}, 32'd0);
    chk("loss_d3_ready", {31'd0, ready}, 32'd0);
    chk("loss_d3_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("loss_d3_count", {24'd0, lock_loss_count}, 32'd1);
    repeat (4) step();
    chk("loss_d7_pll_rst", {31'd0, pll_rst}, 32'd0);
    relock("lock2");

    // Software re-reset request in RUN.
    pll_reset_req = 1'b1;
    step();
    pll_reset_req = 1'b0;
    chk("req_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("req_sys", {31'd0, sys_reset_n}, 32'd0);
    chk("req_ready", {31'd0, ready}, 32'd0);
    chk("req_loss", {24'd0, lock_loss_count}, 32'd1);
    chk("req_tmo", {24'd0, timeout_count}, 32'd2);

    // One-cycle lock glitch while STABLE cnt=5.
    repeat (8) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    repeat (2) step();
    chk("glitch_state_wait", {29'd0, dbg_state}, 32'd1);
    chk("glitch_pll_rst", {31'd0, pll_rst}, 32'd0);
    chk("glitch_sys", {31'd0, sys_reset_n}, 32'd0);
    repeat (8) step();
    chk("glitch_sys_r19", {31'd0, sys_reset_n}, 32'd0);
    step();
    chk("glitch_sys_r20", {31'd0, sys_reset_n}, 32'd1);
    chk("glitch_loss", {24'd0, lock_loss_count}, 32'd1);
    chk("glitch_tmo", {24'd0, timeout_count}, 32'd2);
    repeat (3) step();
    chk("glitch_ready", {31'd0, ready}, 32'd1);

    // 300 further lock losses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      wait_sig(0, 40, $sformatf("sat_wait_sys_%0d", i));
      pll_locked = 1'b0;
      wait_sig(1, 10, $sformatf("sat_wait_pll_rst_%0d", i));
      pll_locked = 1'b1;
      if (i == 252) chk("sat_254", {24'd0, lock_loss_count}, 32'd254);
    end
    chk("sat_255", {24'd0, lock_loss_count}, 32'd255);
    chk("sat_tmo", {24'd0, timeout_count}, 32'd2);

    // Synchronous reset in RUN overrides a concurrent request.
    wait_sig(2, 40, "final_wait_ready");
    reset_n       = 1'b0;
    pll_reset_req = 1'b1;
    step();
    reset_n       = 1'b1;
    pll_reset_req = 1'b0;
    chk("mid_rst_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("mid_rst_sys", {31'd0, sys_reset_n}, 32'd0);
    chk("mid_rst_vid", {31'd0, video_reset_n}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_loss", {24'd0, lock_loss_count}, 32'd0);
    chk("mid_rst_tmo", {24'd0, timeout_count}, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on pll_locked.
REQ-002 Parameter PLL_RST_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset.
REQ-003 Parameter LOCK_TIMEOUT, default 65535: number of WAIT_LOCK cycles allowed before the PLL is reset again.
REQ-004 Parameter STABLE_CYCLES, default 1024: number of consecutive locked cycles required before sys release.
REQ-005 Parameter STAGGER_CYCLES, default 64: delay between sys_reset_n release and video_reset_n release.
REQ-006 clk  in  1  free-running reference clock (PLL refclk domain, never a PLL output).
REQ-007 reset_n  in  1  reset, synchronous and active-low.
REQ-008 pll_locked  in  1  PLL locked flag, asynchronous to clk.
REQ-009 pll_reset_req  in  1  single-cycle software request to re-reset the PLL.
REQ-010 pll_rst  out  1  active-high reset driven to the PLL rst input.
REQ-011 sys_reset_n  out  1  active-low reset for the 100 MHz system logic.
REQ-012 video_reset_n  out  1  active-low reset for the 65 MHz video logic.
REQ-013 ready  out  1  high when the sequence has completed (state RUN).
REQ-014 lock_loss_count  out  8  count of lock losses in REL_SYS/RUN, saturating at 255.
REQ-015 timeout_count  out  8  count of WAIT_LOCK timeouts, saturating at 255.

Function
REQ-016 pll_locked SHALL pass through SYNC_STAGES flops; locked_s denotes the last flop; all decisions use only locked_s.
REQ-017 The FSM SHALL have the states PLL_RST, WAIT_LOCK, STABLE, REL_SYS and RUN, and a single cycle counter cnt that is cleared on every state change.
REQ-018 In PLL_RST, pll_rst=1; after PLL_RST_CYCLES cycles the FSM SHALL go to WAIT_LOCK.
REQ-019 In WAIT_LOCK, locked_s=1 SHALL cause a transition to STABLE.
REQ-020 In WAIT_LOCK, if cnt reaches LOCK_TIMEOUT-1 with locked_s=0, the FSM SHALL go to PLL_RST and increment timeout_count; if lock and timeout occur on the same cycle, lock wins.
REQ-021 In STABLE, cnt SHALL increment while locked_s=1; at cnt==STABLE_CYCLES-1 with locked_s=1 the FSM SHALL go to REL_SYS; locked_s=0 SHALL cause a return to WAIT_LOCK with no PLL reset and no count change.
REQ-022 REL_SYS SHALL last STAGGER_CYCLES cycles and then go to RUN.
REQ-023 A locked_s=0 in REL_SYS or RUN SHALL cause a transition to PLL_RST and increment lock_loss_count.
REQ-024 pll_reset_req=1 in any state SHALL cause a transition to PLL_RST with counts unchanged; if it coincides with a lock loss in REL_SYS/RUN, the loss is still counted.
REQ-025 Outputs SHALL be registered and updated on the same edge as the state: sys_reset_n=1 only in REL_SYS/RUN; video_reset_n=1 and ready=1 only in RUN; pll_rst=1 only in PLL_RST.
REQ-026 On entering PLL_RST, both resets SHALL assert on that same edge, with no glitch or one-cycle gap.
REQ-027 Counters SHALL hold at 255 (no wrap).

Reset
REQ-028 While reset_n=0 at a clk edge: state=PLL_RST, cnt=0, synchronizer flops=0, pll_rst=1, sys_reset_n=0, video_reset_n=0, ready=0, both counts=0.
REQ-029 reset_n asserted mid-operation SHALL take effect on the next edge, overriding all other events.
REQ-030 After reset_n rises, a full PLL_RST_CYCLES pulse SHALL be issued before any lock evaluation.

Verification (bench params: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGGER_CYCLES=3)
REQ-031 Hold pll_locked=0 after reset -> pll_rst high 4 cycles, low 20 cycles, high again; timeout_count=1, then 2 after the next timeout; resets stay asserted.
REQ-032 Raise pll_locked during WAIT_LOCK (first sampling edge E0) -> sys_reset_n rises at E10, video_reset_n and ready rise at E13, pll_rst stays 0.
REQ-033 Drop pll_locked for 1 cycle while STABLE cnt=5 -> return to WAIT_LOCK, no pll_rst pulse, sys_reset_n stays 0, full 8-cycle stability restarts.
REQ-034 Drop pll_locked in RUN -> on the 3rd edge after the drop, sys_reset_n=0, video_reset_n=0, ready=0, pll_rst=1, lock_loss_count=1; relock repeats the REQ-032 timing.
REQ-035 Pulse pll_reset_req in RUN -> next edge enters PLL_RST with both counts unchanged; force 300 lock losses -> lock_loss_count=255.
REQ-036 Assert reset_n=0 for one cycle in RUN -> next edge all outputs at their reset values and counts=0.
